// File: rtl/i2c_master_core.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte, STOP.
// Optional clock stretching when I2C_CLK_STRETCH_EN is defined.
module i2c_master_core #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       wren,
  input  logic       rden,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       irq
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_START = 4'd1;
  localparam logic [3:0] S_ADDR  = 4'd2;
  localparam logic [3:0] S_AACK  = 4'd3;
  localparam logic [3:0] S_WDATA = 4'd4;
  localparam logic [3:0] S_WACK  = 4'd5;
  localparam logic [3:0] S_RDATA = 4'd6;
  localparam logic [3:0] S_RNACK = 4'd7;
  localparam logic [3:0] S_STOP  = 4'd8;

  logic [3:0] state_q, state_d;
  logic [7:0] qcnt_q, qcnt_d;
  logic [1:0] qtr_q, qtr_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] txlat_q, txlat_d;
  logic       rwlat_q, rwlat_d;
  logic       ack_q, ack_d;
  logic       ctrl_rw_q, ctrl_rw_d;
  logic       irq_en_q, irq_en_d;
  logic [6:0] saddr_q, saddr_d;
  logic [7:0] txdata_q, txdata_d;
  logic [7:0] rxdata_q, rxdata_d;
  logic       done_q, done_d;
  logic       nack_q, nack_d;
  logic [7:0] rdata_q, rdata_d;

  logic busy, start_acc, hold, q_end, slot_end, sample;

  assign busy      = (state_q != S_IDLE);
  assign start_acc = ce && wren && (addr == 8'h00) && wdata[0] && !busy;

`ifdef I2C_CLK_STRETCH_EN
  // A slave holding SCL low while we release it freezes the quarter timer.
  assign hold = busy && ((qtr_q == 2'd1) || (qtr_q == 2'd2)) && !scl_i;
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign hold       = 1'b0;
`endif

  assign q_end    = busy && !hold && (qcnt_q == 8'(CLK_DIV - 1));
  assign slot_end = q_end && (qtr_q == 2'd3);
  assign sample   = q_end && (qtr_q == 2'd2);

  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    txlat_d   = txlat_q;
    rwlat_d   = rwlat_q;
    ack_d     = ack_q;
    ctrl_rw_d = ctrl_rw_q;
    irq_en_d  = irq_en_q;
    saddr_d   = saddr_q;
    txdata_d  = txdata_q;
    rxdata_d  = rxdata_q;
    done_d    = done_q;
    nack_d    = nack_q;

    if (ce && wren) begin
      case (addr)
        8'h00: begin ctrl_rw_d = wdata[1]; irq_en_d = wdata[2]; end
        8'h01: saddr_d  = wdata[6:0];
        8'h02: txdata_d = wdata;
        8'h04: begin
          if (wdata[1]) done_d = 1'b0;
          if (wdata[2]) nack_d = 1'b0;
        end
        default: ;
      endcase
    end

    // FSM updates come after register writes so a status set beats a W1C.
    if (start_acc) begin
      state_d = S_START;
      qcnt_d  = 8'd0;
      qtr_d   = 2'd0;
      bit_d   = 3'd0;
      shift_d = {saddr_q, wdata[1]};
      txlat_d = txdata_q;
      rwlat_d = wdata[1];
      done_d  = 1'b0;
      nack_d  = 1'b0;
    end else if (busy && !hold) begin
      if (q_end) begin
        qcnt_d = 8'd0;
        qtr_d  = qtr_q + 2'd1;
      end else begin
        qcnt_d = qcnt_q + 8'd1;
      end
      if (sample) begin
        if (state_q == S_AACK || state_q == S_WACK) ack_d = sda_i;
        if (state_q == S_RDATA) shift_d = {shift_q[6:0], sda_i};
      end
      if (slot_end) begin
        case (state_q)
          S_START: begin state_d = S_ADDR; bit_d = 3'd0; end
          S_ADDR, S_WDATA: begin
            shift_d = {shift_q[6:0], 1'b0};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = (state_q == S_ADDR) ? S_AACK : S_WACK;
          end
          S_AACK: begin
            bit_d = 3'd0;
            if (ack_q) begin
              nack_d  = 1'b1;
              state_d = S_STOP;
            end else if (rwlat_q) begin
              state_d = S_RDATA;
            end else begin
              state_d = S_WDATA;
              shift_d = txlat_q;
            end
          end
          S_WACK: begin
            if (ack_q) nack_d = 1'b1;
            state_d = S_STOP;
          end
          S_RDATA: begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              rxdata_d = shift_q;
              state_d  = S_RNACK;
            end
          end
          S_RNACK: state_d = S_STOP;
          S_STOP: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (ce && rden) begin
      case (addr)
        8'h00:   rdata_d = {5'd0, irq_en_q, ctrl_rw_q, 1'b0};
        8'h01:   rdata_d = {1'b0, saddr_q};
        8'h02:   rdata_d = txdata_q;
        8'h03:   rdata_d = rxdata_q;
        8'h04:   rdata_d = {5'd0, nack_q, done_q, busy};
        default: rdata_d = 8'h00;
      endcase
    end
  end

  // Line drive is decoded from registered state, so reset releases both lines at once.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state_q)
      S_START: begin
        scl_oe = (qtr_q == 2'd3);
        sda_oe = (qtr_q >= 2'd2);
      end
      S_ADDR, S_WDATA: begin
        scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
        sda_oe = ~shift_q[7];
      end
      S_AACK, S_WACK, S_RDATA, S_RNACK: begin
        scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
      end
      S_STOP: begin
        scl_oe = (qtr_q == 2'd0);
        sda_oe = (qtr_q <= 2'd1);
      end
      default: ;
    endcase
  end

  assign rdata = rdata_q;
  assign irq   = done_q & irq_en_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      qcnt_q    <= 8'd0;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      txlat_q   <= 8'd0;
      rwlat_q   <= 1'b0;
      ack_q     <= 1'b0;
      ctrl_rw_q <= 1'b0;
      irq_en_q  <= 1'b0;
      saddr_q   <= 7'd0;
      txdata_q  <= 8'd0;
      rxdata_q  <= 8'd0;
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
      rdata_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      txlat_q   <= txlat_d;
      rwlat_q   <= rwlat_d;
      ack_q     <= ack_d;
      ctrl_rw_q <= ctrl_rw_d;
      irq_en_q  <= irq_en_d;
      saddr_q   <= saddr_d;
      txdata_q  <= txdata_d;
      rxdata_q  <= rxdata_d;
      done_q    <= done_d;
      nack_q    <= nack_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_i2c_master_core.sv
// Bench for i2c_master_core: register table, bus-level slave model with a
// byte scoreboard, and timed transfer sequences (CLK_DIV = 4).
module tb_i2c_master_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0, wren = 1'b0, rden = 1'b0;
  logic [7:0] addr = 8'h00, wdata = 8'h00;
  logic [7:0] rdata;
  logic       scl_oe, sda_oe, irq;
  logic       scl_bus, sda_line, scl_in;
  logic       stretch = 1'b0;
  logic       slave_pull = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  assign scl_bus  = ~scl_oe;
  assign scl_in   = scl_bus & ~stretch;
  assign sda_line = ~sda_oe & ~slave_pull;

  i2c_master_core #(.CLK_DIV(4)) dut (
    .clk(clk), .reset(rst_n), .ce(ce), .wren(wren), .rden(rden),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .scl_i(scl_in), .sda_i(sda_line), .scl_oe(scl_oe), .sda_oe(sda_oe), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard of bytes expected on the wire.
  logic [7:0] exp_q[$];

  task automatic sb_pop(input string name, input logic [7:0] got);
    if (exp_q.size() == 0) chk({name, " unexpected"}, int'(got), -1);
    else chk(name, int'(got), int'(exp_q.pop_front()));
  endtask

  // Slave model: detects START/STOP, captures bits on SCL rise, drives on SCL fall.
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic       mon_act = 1'b0, rd_mode = 1'b0;
  logic [7:0] mshift = 8'h00;
  int         bitn = 0;
  logic       ack_addr = 1'b1, ack_data = 1'b1;
  logic [7:0] rd_byte = 8'h3C;

  always @(scl_bus or sda_line) begin
    if (scl_bus && prev_scl && prev_sda && !sda_line) begin
      mon_act = 1'b1;
      bitn = 0;
    end else if (scl_bus && prev_scl && !prev_sda && sda_line) begin
      mon_act = 1'b0;
    end else if (scl_bus && !prev_scl && mon_act) begin
      mshift = {mshift[6:0], sda_line};
      bitn++;
      if (bitn == 8) begin
        rd_mode = mshift[0];
        sb_pop("addr byte", mshift);
      end else if (bitn == 17) begin
        sb_pop("data byte", mshift);
      end
    end else if (!scl_bus && prev_scl) begin
      if (!mon_act) slave_pull = 1'b0;
      else if (bitn == 8) slave_pull = ack_addr;
      else if (rd_mode && bitn >= 9 && bitn <= 16) slave_pull = ~rd_byte[16 - bitn];
      else if (!rd_mode && bitn == 17) slave_pull = ack_data;
      else slave_pull = 1'b0;
    end
    prev_scl = scl_bus;
    prev_sda = sda_line;
  end

  int t_acc = 0;

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ce = 1'b1; wren = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    ce = 1'b0; wren = 1'b0;
    t_acc = cyc;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    @(negedge clk);
    ce = 1'b1; rden = 1'b1; addr = a;
    @(posedge clk); #1;
    ce = 1'b0; rden = 1'b0;
    v = rdata;
  endtask

  task automatic wait_done(input int t0, output int dur);
    int n = 0;
    while (!irq && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!irq) chk("done timeout", 0, 1);
    dur = cyc - t0;
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[] = '{
    '{1'b0, 8'h00, 8'h00, 8'h00}, '{1'b0, 8'h01, 8'h00, 8'h00},
    '{1'b0, 8'h02, 8'h00, 8'h00}, '{1'b0, 8'h03, 8'h00, 8'h00},
    '{1'b0, 8'h04, 8'h00, 8'h00},
    '{1'b1, 8'h01, 8'hD0, 8'h00}, '{1'b0, 8'h01, 8'h00, 8'h50},
    '{1'b1, 8'h02, 8'h5A, 8'h00}, '{1'b0, 8'h02, 8'h00, 8'h5A},
    '{1'b1, 8'h00, 8'h06, 8'h00}, '{1'b0, 8'h00, 8'h00, 8'h06},
    '{1'b1, 8'h03, 8'hFF, 8'h00}, '{1'b0, 8'h03, 8'h00, 8'h00},
    '{1'b1, 8'h09, 8'h12, 8'h00}, '{1'b0, 8'h09, 8'h00, 8'h00},
    '{1'b1, 8'h00, 8'h00, 8'h00}, '{1'b0, 8'h00, 8'h00, 8'h00},
    '{1'b0, 8'h02, 8'h00, 8'h5A}
  };

  initial begin
    logic [7:0] v;
    int dur, t0, exp_str;

    #2;
    chk("reset rdata", int'(rdata), 0);
    chk("reset scl_oe", int'(scl_oe), 0);
    chk("reset sda_oe", int'(sda_oe), 0);
    chk("reset irq", int'(irq), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    foreach (vt[i]) begin
      if (vt[i].wr) wr(vt[i].a, vt[i].d);
      else begin
        rd(vt[i].a, v);
        chk($sformatf("reg[%0d] a=%0h", i, vt[i].a), int'(v), int'(vt[i].exp));
      end
    end
    repeat (3) @(posedge clk);
    #1 chk("rdata hold", int'(rdata), 8'h5A);

    // Write transfer, slave ACKs address and data.
    ack_addr = 1'b1; ack_data = 1'b1;
    wr(8'h01, 8'h50); wr(8'h02, 8'hA5);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA5);
    wr(8'h00, 8'h05);
    t0 = t_acc;
    wait_done(t0, dur);
    chk("write duration", dur, 320);
    chk("write irq", int'(irq), 1);
    rd(8'h04, v); chk("write status", int'(v), 8'h02);

    // Read transfer, slave returns 0x3C.
    exp_q.push_back(8'hA1); exp_q.push_back(8'h3C);
    wr(8'h00, 8'h07);
    t0 = t_acc;
    #1 chk("irq cleared on start", int'(irq), 0);
    wait_done(t0, dur);
    chk("read duration", dur, 320);
    rd(8'h03, v); chk("rxdata", int'(v), 8'h3C);
    rd(8'h04, v); chk("read status", int'(v), 8'h02);

    // No slave: address NACK, early STOP.
    ack_addr = 1'b0;
    exp_q.push_back(8'hA0);
    wr(8'h00, 8'h05);
    t0 = t_acc;
    wait_done(t0, dur);
    chk("nack duration", dur, 176);
    rd(8'h04, v); chk("nack status", int'(v), 8'h06);
    wr(8'h00, 8'h00); chk("irq masked", int'(irq), 0);
    wr(8'h00, 8'h04); chk("irq unmasked", int'(irq), 1);
    wr(8'h04, 8'h06);
    rd(8'h04, v); chk("w1c status", int'(v), 8'h00);
    chk("w1c irq", int'(irq), 0);
    ack_addr = 1'b1;

    // Start and TXDATA writes while busy leave the transfer untouched.
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA5);
    wr(8'h00, 8'h05);
    t0 = t_acc;
    wr(8'h00, 8'h05);
    wr(8'h02, 8'hFF);
    rd(8'h02, v); chk("txdata rewritten", int'(v), 8'hFF);
    wait_done(t0, dur);
    chk("busy-write duration", dur, 320);
    rd(8'h04, v); chk("busy-write status", int'(v), 8'h02);

    // Reset mid-transfer at clock 100 (ADDR bit 5, SDA held low).
    wr(8'h02, 8'hA5);
    wr(8'h00, 8'h05);
    t0 = t_acc;
    rd(8'h04, v); chk("busy status", int'(v), 8'h01);
    while (cyc - t0 < 100) begin @(posedge clk); #1; end
    chk("pre-reset sda_oe", int'(sda_oe), 1);
    rst_n = 1'b0;
    #1;
    chk("async scl_oe", int'(scl_oe), 0);
    chk("async sda_oe", int'(sda_oe), 0);
    chk("async rdata", int'(rdata), 0);
    @(negedge clk) rst_n = 1'b1;
    rd(8'h04, v); chk("post-reset status", int'(v), 8'h00);
    chk("post-reset irq", int'(irq), 0);

    // SCL held low 50 clocks over ADDR bit 3; only counts with stretching built in.
`ifdef I2C_CLK_STRETCH_EN
    exp_str = 370;
`else
    exp_str = 320;
`endif
    wr(8'h01, 8'h50); wr(8'h02, 8'hA5);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA5);
    wr(8'h00, 8'h05);
    t0 = t_acc;
    repeat (67) @(posedge clk);
    #1 stretch = 1'b1;
    repeat (51) @(posedge clk);
    #1 stretch = 1'b0;
    wait_done(t0, dur);
    chk("stretch duration", dur, exp_str);
    rd(8'h04, v); chk("stretch status", int'(v), 8'h02);

    repeat (4) @(posedge clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
